// File: rtl/input_stream_reader_req_gen.sv
// -----------------------------------------------------------------------------
// input_stream_reader_req_gen
//
// Splits read descriptors (virtual address, byte length) into host read
// requests. No request is larger than MAX_REQ_BYTES or crosses a
// MAX_REQ_BYTES-aligned boundary. A completion-credit counter limits the
// number of issued-but-uncompleted requests to MAX_OUTSTANDING.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_vaddr/i_len        descriptor start address / byte length
//   i_valid/i_ready      descriptor handshake
//   o_vaddr/o_len/o_last request address / length / last-of-descriptor
//   o_valid/o_ready      request handshake
//   i_cmpl               one-cycle pulse per completed request
//   o_outstanding        current credit count (requests in flight)
//   o_idle               no descriptor, no presented request, no credits used
// -----------------------------------------------------------------------------
module input_stream_reader_req_gen #(
  parameter int VADDR_BITS                = 48,
  parameter int TRANSFER_ADDRESS_LEN_BITS = 28,
  parameter int MAX_REQ_BYTES             = 4096,
  parameter int MAX_OUTSTANDING           = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [VADDR_BITS-1:0]                      i_vaddr,
  input  logic [TRANSFER_ADDRESS_LEN_BITS-1:0]       i_len,
  input  logic                                       i_valid,
  output logic                                       i_ready,
  output logic [VADDR_BITS-1:0]                      o_vaddr,
  output logic [TRANSFER_ADDRESS_LEN_BITS-1:0]       o_len,
  output logic                                       o_last,
  output logic                                       o_valid,
  input  logic                                       o_ready,
  input  logic                                       i_cmpl,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       o_outstanding,
  output logic                                       o_idle
);

  localparam int LW = TRANSFER_ADDRESS_LEN_BITS;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [VADDR_BITS-1:0] OFF_MASK   = VADDR_BITS'(MAX_REQ_BYTES - 1);
  localparam logic [LW-1:0]         REQ_BYTES  = LW'(MAX_REQ_BYTES);
  localparam logic [CW-1:0]         CREDIT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Bytes left to the next aligned boundary, clipped to what remains.
  function automatic logic [LW-1:0] chunk_len(input logic [VADDR_BITS-1:0] addr,
                                              input logic [LW-1:0]         rem);
    logic [LW-1:0] room;
    room = REQ_BYTES - LW'(addr & OFF_MASK);
    return (rem < room) ? rem : room;
  endfunction

  state_t                  state_r, state_s;
  logic [VADDR_BITS-1:0]   cur_addr_r, cur_addr_s;
  logic [LW-1:0]           remaining_r, remaining_s;
  logic [VADDR_BITS-1:0]   vaddr_r, vaddr_s;
  logic [LW-1:0]           len_r, len_s;
  logic                    last_r, last_s;
  logic                    valid_r, valid_s;
  logic                    ready_r, ready_s;
  logic                    idle_r, idle_s;
  logic [CW-1:0]           cnt_r, cnt_s;

  logic                    accept_s;
  logic                    slot_free_s;
  logic [CW-1:0]           cnt_dec_s;
  logic                    credit_ok_s;
  logic                    have_work_s;
  logic [VADDR_BITS-1:0]   src_addr_s;
  logic [LW-1:0]           src_rem_s;
  logic [LW-1:0]           chunk_s;
  logic                    chunk_last_s;
  logic                    load_s;

  // Next-state, chunk split, credit accounting and next output values.
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    vaddr_s     = vaddr_r;
    len_s       = len_r;
    last_s      = last_r;

    accept_s    = i_valid && ready_r && (state_r == ST_IDLE);
    slot_free_s = !valid_r || o_ready;

    if (i_cmpl && (cnt_r != {CW{1'b0}})) begin
      cnt_dec_s = cnt_r - CW'(1'b1);
    end else begin
      cnt_dec_s = cnt_r;
    end
    credit_ok_s = (cnt_dec_s < CREDIT_MAX);

    // In IDLE the first chunk is cut straight from the incoming descriptor
    // so a free slot gets its request on the cycle after acceptance.
    if (state_r == ST_ISSUE) begin
      src_addr_s  = cur_addr_r;
      src_rem_s   = remaining_r;
      have_work_s = 1'b1;
    end else begin
      src_addr_s  = i_vaddr;
      src_rem_s   = i_len;
      have_work_s = accept_s && (i_len != {LW{1'b0}});
    end

    chunk_s      = chunk_len(src_addr_s, src_rem_s);
    chunk_last_s = (chunk_s == src_rem_s);
    load_s       = have_work_s && slot_free_s && credit_ok_s;

    if (valid_r && o_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (have_work_s) begin
          cur_addr_s  = i_vaddr;
          remaining_s = i_len;
          state_s     = ST_ISSUE;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_ISSUE;
      default:  state_s = ST_IDLE;
    endcase

    if (load_s) begin
      vaddr_s     = src_addr_s;
      len_s       = chunk_s;
      last_s      = chunk_last_s;
      valid_s     = 1'b1;
      cur_addr_s  = src_addr_s + VADDR_BITS'(chunk_s);
      remaining_s = src_rem_s - chunk_s;
      state_s     = chunk_last_s ? ST_IDLE : ST_ISSUE;
      cnt_s       = cnt_dec_s + CW'(1'b1);
    end else begin
      cnt_s       = cnt_dec_s;
    end

    ready_s = (state_s == ST_IDLE);
    idle_s  = (state_s == ST_IDLE) && !valid_s && (cnt_s == {CW{1'b0}});
  end

  // State, descriptor progress and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= {VADDR_BITS{1'b0}};
      remaining_r <= {LW{1'b0}};
      vaddr_r     <= {VADDR_BITS{1'b0}};
      len_r       <= {LW{1'b0}};
      last_r      <= 1'b0;
      valid_r     <= 1'b0;
      ready_r     <= 1'b1;
      idle_r      <= 1'b1;
      cnt_r       <= {CW{1'b0}};
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      remaining_r <= remaining_s;
      vaddr_r     <= vaddr_s;
      len_r       <= len_s;
      last_r      <= last_s;
      valid_r     <= valid_s;
      ready_r     <= ready_s;
      idle_r      <= idle_s;
      cnt_r       <= cnt_s;
    end
  end

  assign i_ready       = ready_r;
  assign o_vaddr       = vaddr_r;
  assign o_len         = len_r;
  assign o_last        = last_r;
  assign o_valid       = valid_r;
  assign o_outstanding = cnt_r;
  assign o_idle        = idle_r;

endmodule

// File: tb/tb_input_stream_reader_req_gen.sv
// -----------------------------------------------------------------------------
// Bench for input_stream_reader_req_gen. Instance a uses the default
// parameters; instance b limits MAX_OUTSTANDING to 2 for the credit scenario.
// Expected requests of instance a are queued when a descriptor is driven and
// compared on each output handshake.
// -----------------------------------------------------------------------------
module tb_input_stream_reader_req_gen;

  typedef struct packed {
    logic [47:0] va;
    logic [27:0] len;
    logic        last;
  } req_t;

  logic        clk;
  logic        rst_n;

  logic [47:0] a_vaddr, a_ovaddr;
  logic [27:0] a_len, a_olen;
  logic        a_ivalid, a_iready, a_olast, a_ovalid, a_oready, a_cmpl, a_idle;
  logic [3:0]  a_outst;

  logic [47:0] b_vaddr, b_ovaddr;
  logic [27:0] b_len, b_olen;
  logic        b_ivalid, b_iready, b_olast, b_ovalid, b_oready, b_cmpl, b_idle;
  logic [1:0]  b_outst;

  logic        echo_en, man_cmpl, hs_d1, hs_d2;
  int          b_hs_cnt;
  int          checks;
  int          failures;
  req_t        exp_q[$];

  input_stream_reader_req_gen dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_vaddr(a_vaddr), .i_len(a_len), .i_valid(a_ivalid), .i_ready(a_iready),
    .o_vaddr(a_ovaddr), .o_len(a_olen), .o_last(a_olast), .o_valid(a_ovalid),
    .o_ready(a_oready), .i_cmpl(a_cmpl), .o_outstanding(a_outst), .o_idle(a_idle)
  );

  input_stream_reader_req_gen #(.MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_vaddr(b_vaddr), .i_len(b_len), .i_valid(b_ivalid), .i_ready(b_iready),
    .o_vaddr(b_ovaddr), .o_len(b_olen), .o_last(b_olast), .o_valid(b_ovalid),
    .o_ready(b_oready), .i_cmpl(b_cmpl), .o_outstanding(b_outst), .o_idle(b_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion echo: each handshake of instance a returns a completion 2 cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      hs_d1 <= 1'b0;
      hs_d2 <= 1'b0;
    end else begin
      hs_d1 <= echo_en && a_ovalid && a_oready;
      hs_d2 <= hs_d1;
    end
  end
  assign a_cmpl = hs_d2 | man_cmpl;

  // Scoreboard: compare every request of instance a that is about to handshake.
  always @(negedge clk) begin
    if (rst_n && a_ovalid && a_oready) begin
      chk("a_req_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        req_t e;
        e = exp_q.pop_front();
        chk("a_req_vaddr", 64'(a_ovaddr), 64'(e.va));
        chk("a_req_len",   64'(a_olen),   64'(e.len));
        chk("a_req_last",  64'(a_olast),  64'(e.last));
      end
    end
  end

  // Handshake counter for instance b.
  always @(posedge clk) begin
    if (!rst_n) begin
      b_hs_cnt <= 0;
    end else if (b_ovalid && b_oready) begin
      b_hs_cnt <= b_hs_cnt + 1;
    end
  end

  task automatic push(input logic [47:0] va, input logic [27:0] len, input logic last);
    req_t e;
    e.va = va;
    e.len = len;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Present a descriptor to instance a; returns #1 after the accepting edge.
  task automatic send_a(input logic [47:0] va, input logic [27:0] len);
    logic ok;
    ok = 1'b0;
    a_vaddr  = va;
    a_len    = len;
    a_ivalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (a_iready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      tick();
    end
    a_ivalid = 1'b0;
    chk("a_desc_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 60; i++) begin
      if (a_idle) break;
      tick();
    end
    chk("a_idle_reached", 64'(a_idle), 64'd1);
    chk("a_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_vaddr = 48'd0; a_len = 28'd0; a_ivalid = 1'b0; a_oready = 1'b0;
    b_vaddr = 48'd0; b_len = 28'd0; b_ivalid = 1'b0; b_oready = 1'b0; b_cmpl = 1'b0;
    echo_en = 1'b0; man_cmpl = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(a_ovalid), 64'd0);
    chk("rst_o_last",  64'(a_olast),  64'd0);
    chk("rst_outst",   64'(a_outst),  64'd0);
    chk("rst_b_outst", 64'(b_outst),  64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_i_ready", 64'(a_iready), 64'd1);
    chk("rst_idle",    64'(a_idle),   64'd1);

    // 10000 bytes at 0x1000: three back-to-back requests
    echo_en = 1'b1;
    a_oready = 1'b1;
    push(48'h1000, 28'd4096, 1'b0);
    push(48'h2000, 28'd4096, 1'b0);
    push(48'h3000, 28'd1808, 1'b1);
    send_a(48'h1000, 28'd10000);
    chk("t1_c1_valid", 64'(a_ovalid), 64'd1);
    chk("t1_c1_vaddr", 64'(a_ovaddr), 64'h1000);
    tick();
    chk("t1_c2_valid", 64'(a_ovalid), 64'd1);
    tick();
    chk("t1_c3_valid", 64'(a_ovalid), 64'd1);
    chk("t1_c3_last",  64'(a_olast),  64'd1);
    tick();
    chk("t1_c4_valid", 64'(a_ovalid), 64'd0);
    wait_idle_a();

    // Boundary crossing: 512 bytes at 0x0F00
    push(48'h0F00, 28'd256, 1'b0);
    push(48'h1000, 28'd256, 1'b1);
    send_a(48'h0F00, 28'd512);
    wait_idle_a();

    // Zero-length descriptor issues nothing
    send_a(48'h100, 28'd0);
    chk("t3_no_valid",  64'(a_ovalid), 64'd0);
    chk("t3_i_ready",   64'(a_iready), 64'd1);
    tick();
    chk("t3_no_valid2", 64'(a_ovalid), 64'd0);
    push(48'h40, 28'd64, 1'b1);
    send_a(48'h40, 28'd64);
    wait_idle_a();

    // Backpressure: request held stable for 5 cycles
    a_oready = 1'b0;
    push(48'h5000, 28'd100, 1'b1);
    send_a(48'h5000, 28'd100);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 64'(a_ovalid), 64'd1);
      chk("t4_hold_vaddr", 64'(a_ovaddr), 64'h5000);
      chk("t4_hold_len",   64'(a_olen),   64'd100);
      chk("t4_hold_last",  64'(a_olast),  64'd1);
      tick();
    end
    chk("t4_c6_valid", 64'(a_ovalid), 64'd1);
    a_oready = 1'b1;
    tick();
    chk("t4_after_hs_valid", 64'(a_ovalid), 64'd0);
    wait_idle_a();
    man_cmpl = 1'b1;
    tick();
    man_cmpl = 1'b0;
    chk("t4_no_underflow", 64'(a_outst), 64'd0);
    tick();
    chk("t4_idle", 64'(a_idle), 64'd1);

    // Reset in the middle of a multi-chunk descriptor
    push(48'h1000, 28'd4096, 1'b0);
    send_a(48'h1000, 28'd10000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t5_valid",   64'(a_ovalid), 64'd0);
    chk("t5_outst",   64'(a_outst),  64'd0);
    chk("t5_idle",    64'(a_idle),   64'd1);
    chk("t5_i_ready", 64'(a_iready), 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_no_stale", 64'(a_ovalid), 64'd0);
    end

    // Credit limit with MAX_OUTSTANDING=2
    b_oready = 1'b1;
    b_vaddr  = 48'h0;
    b_len    = 28'd16384;
    b_ivalid = 1'b1;
    chk("t6_b_ready", 64'(b_iready), 64'd1);
    tick();
    b_ivalid = 1'b0;
    repeat (4) tick();
    chk("t6_stalled_valid", 64'(b_ovalid), 64'd0);
    chk("t6_outst",         64'(b_outst),  64'd2);
    chk("t6_issued",        64'(b_hs_cnt), 64'd2);
    b_cmpl = 1'b1;
    tick();
    b_cmpl = 1'b0;
    chk("t6_third_valid", 64'(b_ovalid), 64'd1);
    chk("t6_third_vaddr", 64'(b_ovaddr), 64'h2000);
    chk("t6_third_len",   64'(b_olen),   64'd4096);
    chk("t6_third_last",  64'(b_olast),  64'd0);
    chk("t6_net_outst",   64'(b_outst),  64'd2);
    tick();
    chk("t6_issued3", 64'(b_hs_cnt), 64'd3);
    chk("t6_outst3",  64'(b_outst),  64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
